// File: rtl/exe_stage.sv
// Execute stage: operand-2 generation, ALU, branch-target adder and the
// {N,Z,C,V} status register that feeds the condition check in ID.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  exe_cmd,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        imm,
  input  logic        S,
  input  logic [31:0] PC,
  input  logic [31:0] val_Rn,
  input  logic [31:0] val_Rm,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm_24,
  output logic [31:0] alu_result,
  output logic [31:0] br_addr,
  output logic [3:0]  status
);

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } cmd_e;

  logic        mem_access;
  logic [31:0] imm8;
  logic [4:0]  rot;
  logic [4:0]  sh_amt;
  logic [63:0] rot_buf;
  logic [63:0] ror_buf;
  logic [31:0] val2;
  logic [31:0] op_b;
  logic [32:0] sum;
  logic [31:0] result;
  logic        arith;
  logic        c_flag;
  logic        v_flag;
  logic [3:0]  next_flags;
  cmd_e        cmd;

  assign mem_access = mem_read | mem_write;
  assign imm8       = {24'b0, shift_operand[7:0]};
  assign rot        = {shift_operand[11:8], 1'b0};
  assign sh_amt     = shift_operand[11:7];
  // Rotates are taken from the low word of a doubled operand shifted right.
  assign rot_buf    = {imm8, imm8} >> rot;
  assign ror_buf    = {val_Rm, val_Rm} >> sh_amt;

  always_comb begin
    val2 = val_Rm;
    if (imm) begin
      val2 = rot_buf[31:0];
    end else if (mem_access) begin
      val2 = {20'b0, shift_operand};
    end else if (sh_amt != 5'd0) begin
      case (shift_operand[6:5])
        2'b00:   val2 = val_Rm << sh_amt;
        2'b01:   val2 = val_Rm >> sh_amt;
        2'b10:   val2 = $unsigned($signed(val_Rm) >>> sh_amt);
        default: val2 = ror_buf[31:0];
      endcase
    end
  end

  // Loads and stores reuse the adder as an address generator.
  assign cmd = mem_access ? CMD_ADD : cmd_e'(exe_cmd);

  always_comb begin
    result = '0;
    op_b   = '0;
    sum    = '0;
    arith  = 1'b0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD: begin
        op_b  = val2;
        sum   = {1'b0, val_Rn} + {1'b0, op_b};
        arith = 1'b1;
      end
      CMD_ADC: begin
        op_b  = val2;
        sum   = {1'b0, val_Rn} + {1'b0, op_b} + {32'b0, status[1]};
        arith = 1'b1;
      end
      CMD_SUB: begin
        op_b  = ~val2;
        sum   = {1'b0, val_Rn} + {1'b0, op_b} + 33'd1;
        arith = 1'b1;
      end
      CMD_SBC: begin
        op_b  = ~val2;
        sum   = {1'b0, val_Rn} + {1'b0, op_b} + {32'b0, status[1]};
        arith = 1'b1;
      end
      CMD_AND: result = val_Rn & val2;
      CMD_ORR: result = val_Rn | val2;
      CMD_EOR: result = val_Rn ^ val2;
      default: result = '0;
    endcase
    if (arith) begin
      result = sum[31:0];
      c_flag = sum[32];
      v_flag = (val_Rn[31] == op_b[31]) && (sum[31] != val_Rn[31]);
    end
  end

  assign next_flags = {result[31], (result == '0), c_flag, v_flag};
  assign alu_result = result;
  assign br_addr    = PC + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status <= '0;
    end else if (S) begin
      status <= next_flags;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized
// instructions compared every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exe_cmd;
  logic        mem_read, mem_write, imm, S;
  logic [31:0] PC, val_Rn, val_Rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [31:0] alu_result, br_addr;
  logic [3:0]  status;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        checking = 1'b0;
  logic [3:0]  exp_status = '0;
  logic [31:0] cv2, pv2;
  logic [35:0] cexp, pexp;

  exe_stage dut (
    .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .mem_read(mem_read),
    .mem_write(mem_write), .imm(imm), .S(S), .PC(PC), .val_Rn(val_Rn),
    .val_Rm(val_Rm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .alu_result(alu_result),
    .br_addr(br_addr), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_val2(input logic im, input logic mem,
                                          input logic [31:0] rm, input logic [11:0] so);
    logic [31:0] x;
    int r, amt, s;
    if (im) begin
      x = {24'b0, so[7:0]};
      r = 2 * int'(so[11:8]);
      if (r == 0) return x;
      return (x >> r) | (x << (32 - r));
    end
    if (mem) return {20'b0, so};
    amt = int'(so[11:7]);
    if (amt == 0) return rm;
    case (so[6:5])
      2'b00: return rm << amt;
      2'b01: return rm >> amt;
      2'b10: begin s = rm; return 32'(s >>> amt); end
      default: return (rm >> amt) | (rm << (32 - amt));
    endcase
  endfunction

  // Returns {result, N, Z, C, V}; C and V come from exact 64-bit arithmetic.
  function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic mem,
                                         input logic [31:0] rn, input logic [31:0] v2,
                                         input logic cin);
    longint ua, ub, sa, sb, full, sfull, cv;
    logic [31:0] res;
    logic c, v;
    int rs;
    logic [3:0] op;
    ua = rn; ub = v2; sa = $signed(rn); sb = $signed(v2); cv = cin;
    op = mem ? 4'd2 : cmd;
    res = '0; c = 1'b0; v = 1'b0; sfull = 0;
    case (op)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        if (op == 4'd2) cv = 0;
        full  = ua + ub + cv;
        res   = full[31:0];
        c     = full >= 64'sh1_0000_0000;
        sfull = sa + sb + cv;
        rs = res; v = sfull != longint'(rs);
      end
      4'd4, 4'd5: begin
        cv    = (op == 4'd4) ? 0 : 1 - cv;
        full  = ua - ub - cv;
        res   = full[31:0];
        c     = ua >= ub + cv;
        sfull = sa - sb - cv;
        rs = res; v = sfull != longint'(rs);
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: res = '0;
    endcase
    return {res, res[31], res == 32'd0, c, v};
  endfunction

  function automatic logic [31:0] m_br(input logic [31:0] pc, input logic [23:0] off);
    int o;
    o = {{8{off[23]}}, off};
    return pc + 32'(o * 4);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge rst) exp_status = '0;

  always @(posedge clk) begin
    if (rst === 1'b1 && S === 1'b1) begin
      pv2  = m_val2(imm, mem_read | mem_write, val_Rm, shift_operand);
      pexp = m_alu(exe_cmd, mem_read | mem_write, val_Rn, pv2, exp_status[1]);
      exp_status = pexp[3:0];
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      cv2  = m_val2(imm, mem_read | mem_write, val_Rm, shift_operand);
      cexp = m_alu(exe_cmd, mem_read | mem_write, val_Rn, cv2, exp_status[1]);
      chk("alu_result", alu_result, cexp[35:4]);
      chk("br_addr", br_addr, m_br(PC, signed_imm_24));
      chk("status", {28'b0, status}, {28'b0, exp_status});
    end
  end

  task automatic drive(input logic [3:0] cmd, input logic mr, input logic mw,
                       input logic im, input logic s, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [11:0] so,
                       input logic [31:0] pc, input logic [23:0] off);
    exe_cmd = cmd; mem_read = mr; mem_write = mw; imm = im; S = s;
    val_Rn = rn; val_Rm = rm; shift_operand = so; PC = pc; signed_imm_24 = off;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd0, 0, 0, 0, 0, 0, 0, 12'h0, 0, 24'h0);
    #1 rst = 1'b0;
    #1 chk("reset_status", {28'b0, status}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    next_cycle();
    checking = 1'b1;

    drive(4'b0010, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 12'h001, 0, 24'h0);
    #1 chk("add_result", alu_result, 32'h0);
    next_cycle();
    chk("add_status", {28'b0, status}, 32'h6);

    drive(4'b0011, 0, 0, 1, 0, 32'd5, 0, 12'h003, 0, 24'h0);
    #1 chk("adc_result", alu_result, 32'd9);
    next_cycle();
    chk("adc_status_held", {28'b0, status}, 32'h6);

    drive(4'b0100, 0, 0, 0, 1, 32'h8000_0000, 32'h1, 12'h000, 0, 24'h0);
    #1 chk("sub_result", alu_result, 32'h7FFF_FFFF);
    next_cycle();
    chk("sub_status", {28'b0, status}, 32'h3);

    drive(4'b0001, 0, 0, 0, 0, 0, 32'h8000_0001, 12'h0C0, 0, 24'h0);
    #1 chk("mov_asr", alu_result, 32'hC000_0000);
    next_cycle();

    drive(4'b0000, 1, 0, 0, 0, 32'h400, 0, 12'h00C, 32'h100, 24'hFFFFFE);
    #1 chk("br_addr_neg", br_addr, 32'h0F8);
    chk("ldr_addr", alu_result, 32'h40C);
    next_cycle();

    drive(4'b0000, 0, 0, 0, 0, 0, 0, 12'h000, 0, 24'h0);
    next_cycle();
    chk("flush_status_held", {28'b0, status}, 32'h3);

    drive(4'b0001, 0, 0, 1, 0, 0, 0, 12'hF01, 0, 24'h0);
    #1 chk("imm_rot30", alu_result, 32'h4);
    next_cycle();
    drive(4'b0001, 0, 0, 1, 0, 0, 0, 12'h0AB, 0, 24'h0);
    #1 chk("imm_rot0", alu_result, 32'hAB);
    next_cycle();

    drive(4'b0010, 0, 0, 1, 1, 32'h7FFF_FFFF, 0, 12'h001, 0, 24'h0);
    next_cycle();
    chk("ovf_status", {28'b0, status}, 32'h9);
    #2 rst = 1'b0;
    #1 chk("async_clear", {28'b0, status}, 32'h0);
    next_cycle();
    chk("reset_hold", {28'b0, status}, 32'h0);
    drive(4'b0100, 0, 0, 0, 1, 32'd3, 32'd3, 12'h000, 0, 24'h0);
    @(negedge clk) rst = 1'b1;
    next_cycle();
    chk("cmp_after_reset", {28'b0, status}, 32'h6);

    for (int unsigned i = 0; i < 400; i++) begin
      logic mem;
      mem = ($urandom_range(0, 7) == 0);
      drive(4'($urandom_range(0, 15)), mem & ~1'($urandom_range(0, 1)),
            mem & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            mem ? 1'b0 : 1'($urandom_range(0, 1)), pick(), pick(),
            12'($urandom), pick(), 24'($urandom));
      if (mem && !mem_read && !mem_write) mem_read = 1'b1;
      next_cycle();
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
